dot_product_sequencer: RTL

Sequences a batch of dot-product jobs. It reads operand-vector pairs from the two source memories (mem1/mem2) at a shared address and streams them into the dotProduct engine with a valid/ready handshake. It collects the in-order results and writes them, zero-extended, to the result memory (mem3). It replaces manual start_processing control with a programmable job: source base, destination base and length, plus busy/done status and abort.

---
 rtl/dot_product_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dot_product_sequencer.sv
// Purpose: runs a programmable batch of dot-product jobs: reads operand pairs, feeds the engine, writes results back.
// Latency: start sampled at edge 0 -> rd_en in cycle 1 -> eng_valid in cycle 3; result written the cycle after eng_res_valid.
// Backpressure: eng_valid/eng_a/eng_b hold until eng_ready; reads throttle on buffer space and an outstanding-read credit limit.

module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             full, do_push, do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage, pointers and occupancy; flush drops contents but keeps storage values.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module dot_product_sequencer #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 5,
   parameter int RESULT_WIDTH    = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [ADDR_WIDTH-1:0]   src_base,
   input  logic [ADDR_WIDTH-1:0]   dst_base,
   input  logic [ADDR_WIDTH:0]     length,
   output logic                    busy,
   output logic                    done,
   output logic                    rd_en,
   output logic [ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0]   rd_data_a,
   input  logic [DATA_WIDTH-1:0]   rd_data_b,
   output logic                    eng_valid,
   output logic [DATA_WIDTH-1:0]   eng_a,
   output logic [DATA_WIDTH-1:0]   eng_b,
   input  logic                    eng_ready,
   input  logic                    eng_res_valid,
   input  logic [RESULT_WIDTH-1:0] eng_res,
   output logic                    wr_en,
   output logic [ADDR_WIDTH-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0]   wr_data
);
   localparam int CW = ADDR_WIDTH + 1;
   localparam logic [CW-1:0] CREDITS = CW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   src_q, dst_q;
   logic [CW-1:0]           len_q, issued, sent, written, outstanding;
   logic                    rd_pend, zero_done, pop, wr_cap, job_go;
   logic [1:0]              buf_count;
   logic                    buf_empty;
   logic [2*DATA_WIDTH-1:0] buf_head;
   logic [2:0]              occ_eff;

   // Two-entry operand buffer; abort flushes it, which also discards an in-flight read.
   sync_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(2)) u_opbuf (
      .clk       (clk),
      .rst       (rst),
      .flush     (abort),
      .push      (rd_pend),
      .push_data ({rd_data_a, rd_data_b}),
      .pop       (pop),
      .head      (buf_head),
      .empty     (buf_empty),
      .count     (buf_count)
   );

   assign eng_valid   = !buf_empty;
   assign eng_a       = buf_head[2*DATA_WIDTH-1:DATA_WIDTH];
   assign eng_b       = buf_head[DATA_WIDTH-1:0];
   assign pop         = eng_valid && eng_ready;
   assign rd_addr     = src_q + issued[ADDR_WIDTH-1:0];
   assign outstanding = issued - written;
   // A pop this cycle frees its slot in time for the read issued now, which keeps one job per cycle.
   assign occ_eff     = {1'b0, buf_count} + {2'b00, rd_pend} - {2'b00, pop};
   assign job_go      = (state == S_IDLE) && start && !abort && (length != '0);
   assign wr_cap      = eng_res_valid && !abort && ((state == S_RUN) || (state == S_DRAIN));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // Next-state logic plus status and read-issue decode; abort overrides every transition.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = zero_done;
      rd_en      = 1'b0;
      case (state)
         S_IDLE:  if (job_go) state_next = S_RUN;
         S_RUN: begin
            busy = 1'b1;
            if (issued == len_q) state_next = S_DRAIN;
            if (!abort && (issued < len_q) && (occ_eff < 3'd2) && (outstanding < CREDITS))
               rd_en = 1'b1;
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (written == len_q) state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (abort) state_next = S_IDLE;
   end

   // Job registers, progress counters and the registered mem3 write port.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q     <= '0;
         dst_q     <= '0;
         len_q     <= '0;
         issued    <= '0;
         sent      <= '0;
         written   <= '0;
         rd_pend   <= 1'b0;
         zero_done <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
      end else begin
         zero_done <= (state == S_IDLE) && start && !abort && (length == '0);
         rd_pend   <= rd_en;
         wr_en     <= wr_cap;
         if (job_go) begin
            src_q   <= src_base;
            dst_q   <= dst_base;
            len_q   <= length;
            issued  <= '0;
            sent    <= '0;
            written <= '0;
         end else begin
            if (rd_en) issued <= issued + 1'b1;
            if (pop)   sent   <= sent + 1'b1;
            if (wr_cap) begin
               written <= written + 1'b1;
               wr_addr <= dst_q + written[ADDR_WIDTH-1:0];
               wr_data <= {{(DATA_WIDTH-RESULT_WIDTH){1'b0}}, eng_res};
            end
         end
      end
   end
endmodule
